// File: rtl/apb_bus_bridge.sv
// apb_bus_bridge: CPU data bus to N-slave APB bridge with region decode, byte strobes and error flagging.
// Optional feature macro: APB_TIMEOUT_EN (bounds the ACCESS wait to TIMEOUT_CYCLES, then errors).
module apb_bus_bridge #(
    parameter int          NUM_SLAVES     = 4,
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter int          REGION_BITS    = 12,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     transfer,
    input  logic                     busWe,
    input  logic [31:0]              busAddr,
    input  logic [31:0]              busWData,
    input  logic [1:0]               store_size,
    output logic [31:0]              busRData,
    output logic                     ready,
    output logic                     busErr,
    output logic [31:0]              PADDR,
    output logic [31:0]              PWDATA,
    output logic                     PWRITE,
    output logic [3:0]               PSTRB,
    output logic [NUM_SLAVES-1:0]    PSEL,
    output logic                     PENABLE,
    input  logic [32*NUM_SLAVES-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]    PREADY
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} stateType;
    stateType state, nextState;
    logic [31:0] offset, slotIdx, wDataRep, selRData, rDataQ;
    logic [3:0] strb;
    logic [NUM_SLAVES-1:0] selQ;
    logic mapped, aligned, selReady, timedOut, errQ;
    // Decode the incoming request and mux the selected slave's response
    always_comb begin
        offset = busAddr - BASE_ADDR;
        slotIdx = offset >> REGION_BITS;
        mapped = busAddr >= BASE_ADDR && slotIdx < 32'(NUM_SLAVES);
        aligned = store_size == 2'b00 ? 1'b1 : store_size == 2'b01 ? !busAddr[0] : busAddr[1:0] == 2'b00;
        strb = store_size == 2'b00 ? 4'b0001 << busAddr[1:0] :
               store_size == 2'b01 ? 4'b0011 << {busAddr[1], 1'b0} : 4'b1111;
        wDataRep = store_size == 2'b00 ? {4{busWData[7:0]}} :
                   store_size == 2'b01 ? {2{busWData[15:0]}} : busWData;
        selReady = |(PREADY & selQ);
        selRData = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            selRData = selRData | (selQ[i] ? PRDATA[32*i +: 32] : 32'h0);
    end
`ifdef APB_TIMEOUT_EN
    logic [7:0] waitCnt;
    // Count ACCESS cycles so a stuck slave cannot hang the CPU
    always_ff @(posedge clk) begin
        if (!reset || state == SETUP) waitCnt <= '0;
        else if (state == ACCESS) waitCnt <= waitCnt + 8'd1;
    end
    // Flag expiry only when the selected slave is still not ready
    always_comb timedOut = state == ACCESS && waitCnt == 8'(TIMEOUT_CYCLES) && !selReady;
`else
    // Without the timeout an ACCESS phase waits for the slave indefinitely
    always_comb timedOut = 1'b0;
`endif
    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= nextState;
    end
    // Next-state logic; errors skip the APB phases and answer directly
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    nextState = transfer ? (mapped && aligned ? SETUP : RESP) : IDLE;
            SETUP:   nextState = ACCESS;
            ACCESS:  nextState = selReady || timedOut ? RESP : ACCESS;
            default: nextState = IDLE;
        endcase
    end
    // Latch the request on acceptance and capture the slave's response
    always_ff @(posedge clk) begin
        if (!reset) begin
            PADDR <= '0;
            PWDATA <= '0;
            PWRITE <= 1'b0;
            PSTRB <= '0;
            selQ <= '0;
            rDataQ <= '0;
            errQ <= 1'b0;
        end else if (state == IDLE && transfer) begin
            PADDR <= busAddr;
            PWDATA <= wDataRep;
            PWRITE <= busWe;
            PSTRB <= busWe ? strb : 4'b0000;
            selQ <= mapped && aligned ? NUM_SLAVES'(1) << slotIdx : '0;
            rDataQ <= '0;
            errQ <= !(mapped && aligned);
        end else if (state == ACCESS && (selReady || timedOut)) begin
            rDataQ <= PWRITE || timedOut ? 32'h0 : selRData;
            errQ <= timedOut;
        end
    end
    // Bus-side outputs derived from the current phase
    always_comb begin
        PSEL = state == SETUP || state == ACCESS ? selQ : '0;
        PENABLE = state == ACCESS;
        ready = state == RESP;
        busRData = ready ? rDataQ : 32'h0;
        busErr = ready && errQ;
    end
endmodule
